// File: rtl/axis_packet_arbiter_pkg.sv
// Stream typedefs shared by the AXI-Stream blocks; optional sideband fields are
// compiled in only when their width macro is defined.
`ifndef AXIS_DATA_WIDTH
`define AXIS_DATA_WIDTH 32
`endif

package axis_packet_arbiter_pkg;

  localparam int DATA_WIDTH = `AXIS_DATA_WIDTH;
`ifdef AXIS_ID_WIDTH
  localparam int ID_WIDTH = 8;
`endif
`ifdef AXIS_DEST_WIDTH
  localparam int DEST_WIDTH = 8;
`endif
`ifdef AXIS_USER_WIDTH
  localparam int USER_WIDTH = 1;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
`ifdef AXIS_ID_WIDTH
    logic [ID_WIDTH-1:0]   tid;
`endif
`ifdef AXIS_DEST_WIDTH
    logic [DEST_WIDTH-1:0] tdest;
`endif
`ifdef AXIS_USER_WIDTH
    logic [USER_WIDTH-1:0] tuser;
`endif
    logic                  tlast;
  } axis_data_t;

  typedef struct packed {
    axis_data_t data;
    logic       tvalid;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

endpackage

// File: rtl/axis_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: requests rotated down by ptr, lowest set bit
// wins, and the winner is mapped back to its absolute channel position.
module axis_packet_arbiter_rr_arbiter #(
  parameter int N = 8,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot;
  logic         found;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        found                    = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin with packet locking, output
// through a 2-entry skid register so input TREADY never sees downstream TREADY.
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  axis_mosi_t                in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t                in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t                out_mosi_o,
  input  axis_miso_t                out_miso_i,
  output logic [CHANNEL_NUMBER-1:0] grant_o,
  output logic                      busy_o
);

  localparam int PW = $clog2(CHANNEL_NUMBER);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]             arb_idx, sel_idx;
  logic [CHANNEL_NUMBER-1:0] req, arb_gnt;
  axis_data_t                sel_data, main_data, spare_data;
  logic                      sel_valid, accept, pop;
  logic                      main_valid, spare_valid, skid_ready;

  // Explicit wrap so non-power-of-2 channel counts cycle correctly.
  function automatic logic [PW-1:0] next_ch(input logic [PW-1:0] ch);
    return (int'(ch) == CHANNEL_NUMBER - 1) ? '0 : ch + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) req[i] = in_mosi_i[i].tvalid;
  end

  axis_packet_arbiter_rr_arbiter #(.N(CHANNEL_NUMBER)) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  assign sel_idx    = (state == LOCKED) ? owner : arb_idx;
  assign skid_ready = !spare_valid;

  always_comb begin
    grant_o = '0;
    if (!ARESET) begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
        grant_o[i] = (state == LOCKED) ? (owner == PW'(i)) : arb_gnt[i];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      in_miso_o[i].tready = grant_o[i] & skid_ready;
      if (grant_o[i]) begin
        sel_valid = in_mosi_i[i].tvalid;
        sel_data  = in_mosi_i[i].data;
      end
    end
  end

  assign accept = sel_valid & skid_ready;
  assign pop    = main_valid & out_miso_i.tready;

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_data.tlast) begin
            rr_ptr_nxt = next_ch(sel_idx);
          end else begin
            state_nxt = LOCKED;
            owner_nxt = sel_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_data.tlast) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = next_ch(owner);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Spare only fills when main is held; no accept is possible while spare is full.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      main_valid  <= 1'b0;
      spare_valid <= 1'b0;
    end else if (spare_valid) begin
      if (pop) begin
        main_data   <= spare_data;
        spare_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid && !pop) begin
        spare_data  <= sel_data;
        spare_valid <= 1'b1;
      end else begin
        main_data  <= sel_data;
        main_valid <= 1'b1;
      end
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

  assign out_mosi_o.data   = main_data;
  assign out_mosi_o.tvalid = main_valid;
  assign busy_o            = (state == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: transaction-level model checked every cycle on
// an 8-channel instance, plus literal checks and a 5-channel wrap instance.
module tb_axis_packet_arbiter;
  import axis_packet_arbiter_pkg::*;

  localparam int N8 = 8;
  localparam int N5 = 5;

  typedef struct { axis_data_t d; int gap; } beat_t;
  typedef struct { int ch; int seq; int cyc; } log_t;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       down_rdy = 1'b1;

  axis_mosi_t in8 [N8];
  axis_miso_t miso8 [N8];
  axis_mosi_t out8;
  axis_miso_t down8;
  logic [N8-1:0] grant8;
  logic       busy8;

  axis_mosi_t in5 [N5];
  axis_miso_t miso5 [N5];
  axis_mosi_t out5;
  axis_miso_t down5;
  logic [N5-1:0] grant5;
  logic       busy5;

  always #5 clk = ~clk;

  assign down8.tready = down_rdy;
  assign down5.tready = 1'b1;

  axis_packet_arbiter #(.CHANNEL_NUMBER(N8)) dut8 (
    .ACLK(clk), .ARESET(areset), .in_mosi_i(in8), .in_miso_o(miso8),
    .out_mosi_o(out8), .out_miso_i(down8), .grant_o(grant8), .busy_o(busy8)
  );

  axis_packet_arbiter #(.CHANNEL_NUMBER(N5)) dut5 (
    .ACLK(clk), .ARESET(areset), .in_mosi_i(in5), .in_miso_o(miso5),
    .out_mosi_o(out5), .out_miso_i(down5), .grant_o(grant5), .busy_o(busy5)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [N8-1:0] fire = '0;
  beat_t      src_q [N8][$];
  int         gap_cnt [N8];
  bit         gap_loaded [N8];
  int         seq_no [N8];
  log_t       out_log [$];
  int         exp_order [$];

  axis_data_t m_q [$];
  bit         m_locked = 1'b0;
  int         m_owner = 0;
  int         m_rr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: owner/rr pointer per the arbitration rules, skid as a 2-deep FIFO whose
  // acceptance depends on occupancy at the start of the cycle.
  always @(negedge clk) begin
    int sel;
    int sz;
    logic [N8-1:0] vld, act_r, exp_g, exp_r;
    sel = -1;
    sz  = m_q.size();
    for (int i = 0; i < N8; i++) begin
      vld[i]   = in8[i].tvalid;
      act_r[i] = miso8[i].tready;
    end
    if (!areset) begin
      if (m_locked) sel = m_owner;
      else
        for (int i = 0; i < N8; i++)
          if (sel < 0 && vld[(m_rr + i) % N8]) sel = (m_rr + i) % N8;
    end
    exp_g = '0;
    if (sel >= 0) exp_g[sel] = 1'b1;
    exp_r = (sz < 2) ? exp_g : '0;
    chk("grant", grant8, exp_g);
    chk("tready", act_r, exp_r);
    chk("busy", busy8, m_locked);
    chk("out_valid", out8.tvalid, sz > 0);
    if (sz > 0) chk("out_data", out8.data, m_q[0]);
    fire = vld & act_r;
    if (out8.tvalid && down_rdy)
      out_log.push_back('{int'(out8.data.tdata[31:24]), int'(out8.data.tdata[7:0]), cyc});
    if (sz > 0 && down_rdy) void'(m_q.pop_front());
    if (sel >= 0 && vld[sel] && sz < 2) begin
      m_q.push_back(in8[sel].data);
      if (!m_locked) begin
        if (in8[sel].data.tlast) m_rr = (sel + 1) % N8;
        else begin
          m_locked = 1'b1;
          m_owner  = sel;
        end
      end else if (in8[sel].data.tlast) begin
        m_locked = 1'b0;
        m_rr     = (m_owner + 1) % N8;
      end
    end
    if (areset) begin
      m_q.delete();
      m_locked = 1'b0;
      m_rr     = 0;
      m_owner  = 0;
    end
  end

  task automatic drive();
    for (int c = 0; c < N8; c++) begin
      if (src_q[c].size() > 0 && gap_cnt[c] == 0) begin
        in8[c].tvalid = 1'b1;
        in8[c].data   = src_q[c][0].d;
      end else begin
        in8[c].tvalid = 1'b0;
        in8[c].data   = '0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int c = 0; c < N8; c++) begin
      if (fire[c] && src_q[c].size() > 0) begin
        void'(src_q[c].pop_front());
        gap_loaded[c] = 1'b0;
      end
      if (src_q[c].size() > 0 && !gap_loaded[c]) begin
        gap_cnt[c]    = src_q[c][0].gap;
        gap_loaded[c] = 1'b1;
      end
    end
    drive();
    for (int c = 0; c < N8; c++)
      if (src_q[c].size() > 0 && gap_cnt[c] > 0) gap_cnt[c]--;
  endtask

  task automatic push_pkt(input int c, input int n, input int gap_idx, input int gap_len);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d       = '0;
      b.d.tdata = {8'(c), 16'h0, 8'(seq_no[c])};
      b.d.tlast = (k == n - 1);
      b.gap     = (k == gap_idx) ? gap_len : 0;
      src_q[c].push_back(b);
      seq_no[c]++;
    end
  endtask

  task automatic chk_order(input string name);
    chk({name, "_count"}, out_log.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < out_log.size(); k++)
      chk(name, out_log[k].ch, exp_order[k]);
  endtask

  initial begin
    int base;
    for (int c = 0; c < N8; c++) begin
      in8[c] = '0; gap_cnt[c] = 0; gap_loaded[c] = 1'b0; seq_no[c] = 0;
    end
    for (int c = 0; c < N5; c++) in5[c] = '0;

    // Reset held with every channel valid; first grant after release is channel 0.
    for (int c = 0; c < N8; c++) push_pkt(c, 1, -1, 0);
    repeat (4) cycle();
    @(negedge clk);
    chk("rst_tready_ch0", miso8[0].tready, 1'b0);
    chk("rst_out_valid", out8.tvalid, 1'b0);
    chk("rst_grant", grant8, '0);
    chk("rst_busy", busy8, 1'b0);
    cycle();
    areset = 1'b0;
    repeat (12) cycle();
    exp_order = {0, 1, 2, 3, 4, 5, 6, 7};
    chk_order("rst_first");
    out_log.delete();

    // Round-robin among channels 0, 3, 5 with no output gaps.
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 1, -1, 0);
      push_pkt(3, 1, -1, 0);
      push_pkt(5, 1, -1, 0);
    end
    repeat (14) cycle();
    exp_order = {0, 3, 5, 0, 3, 5, 0, 3, 5};
    chk_order("rr_order");
    if (out_log.size() == 9) chk("rr_no_gap", out_log[8].cyc - out_log[0].cyc, 8);
    out_log.delete();

    // Packet lock: channel 2 holds the link across its valid gap; channel 1 waits.
    push_pkt(2, 4, 2, 2);
    cycle();
    cycle();
    push_pkt(1, 1, -1, 0);
    repeat (14) cycle();
    exp_order = {2, 2, 2, 2, 1};
    chk_order("lock_order");
    if (out_log.size() == 5) chk("lock_next_gap", out_log[4].cyc - out_log[3].cyc, 1);
    out_log.delete();

    // Backpressure 1,0,0,1 during a 6-beat packet.
    base = seq_no[6];
    push_pkt(6, 6, -1, 0);
    cycle(); down_rdy = 1'b1;
    cycle(); down_rdy = 1'b0;
    cycle(); down_rdy = 1'b0;
    @(negedge clk);
    chk("bp_skid_full", miso8[6].tready, 1'b0);
    cycle(); down_rdy = 1'b1;
    repeat (12) cycle();
    exp_order = {6, 6, 6, 6, 6, 6};
    chk_order("bp_order");
    for (int k = 0; k < out_log.size(); k++) chk("bp_seq", out_log[k].seq, base + k);
    out_log.delete();

    // Reset during beat 3 of 8; afterwards rr pointer is back at 0.
    push_pkt(7, 8, -1, 0);
    cycle(); cycle(); cycle();
    areset = 1'b1;
    cycle();
    areset = 1'b0;
    src_q[7].delete();
    gap_loaded[7] = 1'b0;
    drive();
    @(negedge clk);
    chk("rstmid_out_valid", out8.tvalid, 1'b0);
    chk("rstmid_busy", busy8, 1'b0);
    out_log.delete();
    push_pkt(7, 1, -1, 0);
    push_pkt(3, 1, -1, 0);
    repeat (8) cycle();
    exp_order = {3, 7};
    chk_order("rstmid_order");

    // Five channels: channel 4 wins, pointer wraps to 0, then 0 beats 4.
    in5[4].tvalid = 1'b1;
    in5[4].data.tdata = 32'h0400_0000;
    in5[4].data.tlast = 1'b1;
    @(negedge clk);
    chk("w5_grant_ch4", grant5, 5'b10000);
    cycle();
    in5[4].data.tdata = 32'h0400_0001;
    in5[0].tvalid = 1'b1;
    in5[0].data.tdata = 32'h0000_0000;
    in5[0].data.tlast = 1'b1;
    @(negedge clk);
    chk("w5_grant_ch0", grant5, 5'b00001);
    chk("w5_tready_ch4", miso5[4].tready, 1'b0);
    chk("w5_out_valid", out5.tvalid, 1'b1);
    chk("w5_out_ch4", out5.data.tdata, 32'h0400_0000);
    cycle();
    @(negedge clk);
    chk("w5_grant_after", grant5, 5'b10000);
    chk("w5_out_ch0", out5.data.tdata, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

- N-to-1 AXI-Stream packet arbiter that drains the per-channel FIFOs of the multi-channel stream buffer onto one shared output link.
- Round-robin between channels with packet locking: once a channel wins, it keeps the link until its TLAST beat is transferred.
- Output goes through a 2-entry skid register, giving full throughput with registered outputs.
- Sits between the channel buffers and a shared router/NI port.

## Interface

Parameters:
- CHANNEL_NUMBER, 8: number of requesting channels, ≥2.
- Stream field widths (DATA_WIDTH, optional ID/DEST/USER widths): same `ifdef`-gated set and defaults as the other stream blocks.

Ports:
- ACLK, in, 1: single clock.
- ARESET, in, 1: reset, synchronous, active-high.
- in_mosi_i, in, axis_mosi_t [CHANNEL_NUMBER]: per-channel stream in (data incl. TLAST, TVALID).
- in_miso_o, out, axis_miso_t [CHANNEL_NUMBER]: per-channel TREADY.
- out_mosi_o, out, axis_mosi_t: merged stream out.
- out_miso_i, in, axis_miso_t: downstream TREADY.
- grant_o, out, CHANNEL_NUMBER: one-hot current owner; all-zero when idle.
- busy_o, out, 1: high while in LOCKED.

## Operation

State machine:
- IDLE: the arbiter picks a channel combinationally from TVALIDs, starting at rr_ptr and wrapping.
  - That channel's TREADY = skid_ready.
  - Accepted beat with TLAST=1: stay IDLE, rr_ptr ← winner+1 (mod N).
  - Accepted beat with TLAST=0: go to LOCKED, owner ← winner.
  - No beat accepted (no valid, or skid full): no state change and rr_ptr unchanged.
- LOCKED: only the owner's TREADY may be high (= skid_ready); every other TREADY is 0.
  - Accepted TLAST beat: go to IDLE, rr_ptr ← owner+1.
  - Owner TVALID low: stall in LOCKED. Other channels are never granted mid-packet.

Rules:
- At most one in_miso_o TREADY high per cycle.
- Beats pass through unchanged: the whole data struct is copied.
- grant_o = one-hot of winner (IDLE with a valid present) or owner (LOCKED).
- rr_ptr width is $clog2(CHANNEL_NUMBER); wrap from N-1 to 0 is explicit, so non-power-of-2 N works.

Skid register:
- 2 entries: main + spare.
- skid_ready = spare entry empty. This is registered, so there is no combinational path from out_miso_i.TREADY to in_miso_o.
- out_mosi_o is driven only from the main entry.
- Order is preserved.

## Timing

- Reset (ARESET sampled high at a clock edge): state=IDLE, rr_ptr=0, both skid entries empty, out TVALID=0, all in TREADY=0, grant_o=0, busy_o=0.
- Reset mid-packet: partial packet and buffered beats are discarded; no recovery is attempted.
- Latency: a beat accepted at edge k appears on out_mosi_o after edge k, i.e. 1 cycle.
- Throughput: one beat per cycle sustained while downstream is ready.
- Zero-bubble switching:
  - A single-beat packet from one channel followed by a packet from another channel runs in consecutive cycles.
  - After a TLAST beat in LOCKED, the next grant is made in the following cycle (IDLE).
- Downstream TREADY low: the skid absorbs one extra beat; skid_ready falls the cycle after the spare entry fills.
- out TVALID, once high, holds stable with stable data until TREADY is seen (AXI rule).
- Input TREADY may depend on TVALID in IDLE (permitted). No input TVALID depends on TREADY.

## Structure

- Shared package/header: axis_mosi_t, axis_miso_t, axis_data_t (existing stream typedefs); no new constants.
- Sub-module rr_arbiter (params N):
  - Inputs: req, ptr. Output: one-hot gnt.
  - Purely combinational masked-priority scheme: double-width request vector rotated by ptr.
- The skid buffer stays inline in this block.
- Target size: ~200 lines RTL total.

## Test plan

- Reset: hold ARESET high with all channels valid → all TREADY=0, out TVALID=0, grant_o=0. First grant after release goes to channel 0.
- Round-robin: channels 0, 3, 5 each hold valid 1-beat packets, downstream always ready → output order 0, 3, 5, 0, 3, … with one beat per cycle and no gaps.
- Packet lock: channel 2 sends a 4-beat packet with a 2-cycle valid gap after beat 2 while channel 1 is valid → channel 1 TREADY stays 0 until channel 2's TLAST is transferred; channel 1 is granted next.
- Backpressure: downstream TREADY toggles 1,0,0,1 during a 6-beat packet → no beat lost or duplicated, output data stable while stalled, skid_ready low by the second stall cycle.
- Wrap and non-power-of-2: CHANNEL_NUMBER=5, channel 4 granted, then channels 4 and 0 valid → channel 0 wins; rr_ptr wraps 4→0.
- Reset mid-packet: assert ARESET during beat 3 of 8 → out TVALID=0 the next cycle; after release the arbiter is in IDLE with rr_ptr=0.
